vscale_dmem_bridge: RTL and testbench
=====================================

VSCALE_DMEM_BRIDGE -- requirements
Module: vscale_dmem_bridge

Interface
REQ-001 Parameter STALL_CNT_WIDTH, default 16, sets the width of the stall-cycle counter.
REQ-002 clk  input  1  core clock; all state is sampled on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 dmem_addr  input  32  core request address.
REQ-005 dmem_read  input  1  core read request.
REQ-006 dmem_write  input  1  core write request.
REQ-007 dmem_size  input  3  access size: 0 = byte, 1 = half, 2 = word.
REQ-008 dmem_wdata  input  32  store data, valid in the cycle after the address cycle.
REQ-009 dmem_rdata  output  32  load data to the core.
REQ-010 dmem_ready  output  1  data phase complete; the core may advance.
REQ-011 dmem_resp  output  1  0 = OKAY, 1 = ERROR, qualified by dmem_ready.
REQ-012 haddr, hwrite, hsize(3), htrans(2), hwdata(32)  output  HASTI master address and data phase signals.
REQ-013 hrdata(32), hready(1), hresp(1)  input  HASTI slave response signals.
REQ-014 stall_clr  input  1  synchronous clear of the stall counter.
REQ-015 stall_cycles  output  STALL_CNT_WIDTH  saturating count of cycles with dmem_ready=0.

Function
REQ-016 The block SHALL implement a state machine with states IDLE (no data phase outstanding), DATA (data phase outstanding), ERR (second cycle of an error response) and MISAL (misaligned-access error reply).
REQ-017 The address phase SHALL be combinational: htrans = NONSEQ (2'b10) whenever (dmem_read|dmem_write) is high, the state is not ERR, and the access is not rejected as misaligned; otherwise htrans = IDLE (2'b00).
REQ-018 In the address phase, haddr = dmem_addr, hwrite = dmem_write, and hsize = dmem_size.
REQ-019 An address phase SHALL be accepted on a rising edge where htrans = NONSEQ and hready = 1; on acceptance the next state is DATA and hwrite is latched into a data-phase register.
REQ-020 In the data phase, hwdata = dmem_wdata and dmem_rdata = hrdata.
REQ-021 dmem_ready SHALL be asserted as follows:
- 1 in IDLE and MISAL;
- hready & ~hresp in DATA;
- hready in ERR.
REQ-022 dmem_resp SHALL be 1 only in ERR with hready = 1, or in MISAL; otherwise it is 0.
REQ-023 In DATA, the transition SHALL be chosen as follows:
- hready=1 & hresp=0, with a new address accepted in the same cycle (back-to-back): stay in DATA;
- hready=1 & hresp=0, with no new address accepted: go to IDLE;
- hready=0 & hresp=1: go to ERR.
REQ-024 In ERR, htrans SHALL be forced to IDLE, and the block returns to IDLE on hready = 1.
REQ-025 The block SHALL NOT change haddr, hwrite, hsize or htrans while hready = 0; the core holds its request stable while dmem_ready = 0.
REQ-026 The block SHALL add zero cycles of latency: a single-wait-state-free load completes with dmem_ready = 1 in the cycle after the address cycle.
REQ-027 stall_cycles SHALL increment by 1 on each edge where dmem_ready = 0, saturate at all-ones, and clear to 0 when stall_clr = 1; stall_clr has priority over increment.
REQ-028 When dmem_read and dmem_write are both high, the request SHALL be treated as a write.

Reset
REQ-029 While reset is low, the state SHALL be IDLE and stall_cycles and all data-phase registers SHALL be 0.
REQ-030 While reset is low, htrans SHALL be IDLE, dmem_ready = 1, and dmem_resp = 0.
REQ-031 Reset asserted mid-transfer SHALL abandon the outstanding data phase without issuing any further bus cycle.
REQ-032 Release of reset SHALL take effect at the next rising edge of clk.

Configuration
REQ-033 With VSCALE_DMEM_ALIGN_CHECK_EN defined, a half access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL drive htrans = IDLE and move to MISAL.
REQ-034 With VSCALE_DMEM_ALIGN_CHECK_EN defined, MISAL SHALL last exactly one cycle (dmem_ready = 1, dmem_resp = 1) and then return to IDLE.
REQ-035 With VSCALE_DMEM_ALIGN_CHECK_EN undefined, MISAL SHALL be unreachable and all accesses SHALL pass to the bus unchanged.

Verification
REQ-036 Load word at 0x100 with a zero-wait slave returning hrdata = 0xDEADBEEF -> NONSEQ in cycle 0; dmem_ready = 1, dmem_rdata = 0xDEADBEEF, dmem_resp = 0 in cycle 1.
REQ-037 Store 0x12345678 to 0x200 with the slave inserting 2 wait states -> hwdata = 0x12345678 held for 3 cycles, dmem_ready = 0 for 2 cycles, stall_cycles = 2.
REQ-038 Back-to-back loads to 0x0 and 0x4 -> the second NONSEQ overlaps the first data phase; both complete in 3 total cycles.
REQ-039 Slave error on a read of 0x300 -> cycle 1: hready = 0, hresp = 1, dmem_ready = 0, htrans = IDLE; cycle 2: dmem_ready = 1, dmem_resp = 1; state returns to IDLE.
REQ-040 With VSCALE_DMEM_ALIGN_CHECK_EN defined, a word read at 0x102 -> htrans stays IDLE and dmem_resp = 1 one cycle later; with the macro undefined, NONSEQ is issued to 0x102.
REQ-041 Reset asserted during a waited data phase -> state goes to IDLE asynchronously, htrans = IDLE, and stall_cycles = 0.

Source files
------------

// File: rtl/vscale_dmem_bridge.sv
// V-Scale data-memory port to HASTI (AHB-Lite) master bridge with a saturating stall counter.
// Optional misaligned-access rejection is enabled by defining VSCALE_DMEM_ALIGN_CHECK_EN.
module vscale_dmem_bridge #(
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                dmem_addr,
  input  logic                       dmem_read,
  input  logic                       dmem_write,
  input  logic [2:0]                 dmem_size,
  input  logic [31:0]                dmem_wdata,
  output logic [31:0]                dmem_rdata,
  output logic                       dmem_ready,
  output logic                       dmem_resp,
  output logic [31:0]                haddr,
  output logic                       hwrite,
  output logic [2:0]                 hsize,
  output logic [1:0]                 htrans,
  output logic [31:0]                hwdata,
  input  logic [31:0]                hrdata,
  input  logic                       hready,
  input  logic                       hresp,
  input  logic                       stall_clr,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_HALF     = 3'd1;
  localparam logic [2:0] SIZE_WORD     = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_ERR   = 2'd2,
    S_MISAL = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  state_t slot_nxt;
  logic   data_write;
  logic   req_c;
  logic   misal_c;
  logic   accept_c;

  assign req_c = dmem_read | dmem_write;

`ifdef VSCALE_DMEM_ALIGN_CHECK_EN
  assign misal_c = req_c &&
                   (((dmem_size == SIZE_HALF) && dmem_addr[0]) ||
                    ((dmem_size == SIZE_WORD) && (dmem_addr[1:0] != 2'b00)));
`else
  assign misal_c = 1'b0;
`endif

  // Address phase is a pass-through; read+write together already reads as a write.
  assign haddr      = dmem_addr;
  assign hwrite     = dmem_write;
  assign hsize      = dmem_size;
  assign dmem_rdata = hrdata;
  assign hwdata     = ((state == S_DATA) && data_write) ? dmem_wdata : 32'd0;

  // Next state and handshake outputs; slot_nxt is where a consumed address slot leads.
  always_comb begin
    state_nxt  = state;
    htrans     = HTRANS_IDLE;
    dmem_ready = 1'b1;
    dmem_resp  = 1'b0;
    accept_c   = 1'b0;
    slot_nxt   = S_IDLE;

    if (reset && req_c && (state != S_ERR) && !misal_c) begin
      htrans = HTRANS_NONSEQ;
    end
    accept_c = (htrans == HTRANS_NONSEQ) && hready;

    if (accept_c) begin
      slot_nxt = S_DATA;
    end else if (misal_c) begin
      slot_nxt = S_MISAL;
    end

    case (state)
      S_IDLE: begin
        state_nxt = slot_nxt;
      end
      S_MISAL: begin
        dmem_resp = 1'b1;
        state_nxt = slot_nxt;
      end
      S_DATA: begin
        dmem_ready = hready & ~hresp;
        if (hready) begin
          state_nxt = slot_nxt;
        end else if (hresp) begin
          state_nxt = S_ERR;
        end
      end
      S_ERR: begin
        dmem_ready = hready;
        dmem_resp  = hready;
        if (hready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      data_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        data_write <= dmem_write;
      end
    end
  end

  // Stall counter: clear wins over a saturating increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (stall_clr) begin
      stall_cycles <= '0;
    end else if (!dmem_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Directed and randomized bench for vscale_dmem_bridge against a transaction-level model.
module tb_vscale_dmem_bridge;

  localparam int unsigned CW = 4;
  localparam int unsigned STALL_MAX = (1 << CW) - 1;
`ifdef VSCALE_DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   dmem_addr = '0;
  logic          dmem_read = 1'b0;
  logic          dmem_write = 1'b0;
  logic [2:0]    dmem_size = '0;
  logic [31:0]   dmem_wdata = '0;
  logic [31:0]   dmem_rdata;
  logic          dmem_ready;
  logic          dmem_resp;
  logic [31:0]   haddr;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic [31:0]   hwdata;
  logic [31:0]   hrdata = '0;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;
  logic          stall_clr = 1'b0;
  logic [CW-1:0] stall_cycles;

  vscale_dmem_bridge #(.STALL_CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_size(dmem_size), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .dmem_resp(dmem_resp),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .stall_clr(stall_clr), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: which reply the bus/core currently owes, plus the stall tally.
  bit m_dp;          // a bus data phase is outstanding
  bit m_dp_write;    // that data phase is a store
  bit m_err;         // slave is in the second cycle of an error reply
  bit m_misal;       // a misaligned access is being refused this cycle
  bit m_last_ready;  // core saw completion last cycle, so it may present a new request
  int m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dp = 0; m_dp_write = 0; m_err = 0; m_misal = 0; m_last_ready = 1; m_stall = 0;
  endtask

  task automatic core(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd);
    dmem_read = rd; dmem_write = wr; dmem_addr = a; dmem_size = sz; dmem_wdata = wd;
  endtask

  task automatic slave(input bit rdy, input bit rsp, input logic [31:0] rd);
    hready = rdy; hresp = rsp; hrdata = rd;
  endtask

  // One bus cycle: check every output against the model, then advance it at the edge.
  task automatic cyc();
    bit req, mis, exp_ready, exp_resp, acc;
    logic [1:0]  exp_htrans;
    logic [31:0] exp_hwdata;
    #1;
    req = dmem_read || dmem_write;
    mis = ALIGN && req && (((dmem_size == 3'd1) && dmem_addr[0]) ||
                           ((dmem_size == 3'd2) && (dmem_addr[1:0] != 2'b00)));
    exp_htrans = (req && !m_err && !mis) ? 2'b10 : 2'b00;
    if (m_err)     exp_ready = hready;
    else if (m_dp) exp_ready = hready && !hresp;
    else           exp_ready = 1'b1;
    exp_resp   = (m_err && hready) || m_misal;
    exp_hwdata = (m_dp && m_dp_write) ? dmem_wdata : 32'd0;
    chk("htrans", 32'(htrans), 32'(exp_htrans));
    chk("haddr", haddr, dmem_addr);
    chk("hwrite", 32'(hwrite), 32'(dmem_write));
    chk("hsize", 32'(hsize), 32'(dmem_size));
    chk("hwdata", hwdata, exp_hwdata);
    chk("dmem_rdata", dmem_rdata, hrdata);
    chk("dmem_ready", 32'(dmem_ready), 32'(exp_ready));
    chk("dmem_resp", 32'(dmem_resp), 32'(exp_resp));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    acc = (exp_htrans == 2'b10) && hready;
    @(posedge clk);
    if (stall_clr) m_stall = 0;
    else if (!exp_ready && m_stall < int'(STALL_MAX)) m_stall++;
    if (m_err) begin
      if (hready) m_err = 0;
    end else if (m_dp && !hready) begin
      if (hresp) begin
        m_dp = 0;
        m_err = 1;
      end
    end else begin
      m_dp = acc;
      if (acc) m_dp_write = dmem_write;
      m_misal = mis && !acc;
    end
    m_last_ready = exp_ready;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_ready", 32'(dmem_ready), 32'd1);
    chk("rst_resp", 32'(dmem_resp), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    core(0, 0, 32'd0, 3'd0, 32'd0);
    slave(1, 0, 32'd0);
    stall_clr = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #1;
    core(1, 0, 32'h40, 3'd2, 32'd0);
    do_reset();

    // Zero-wait word load.
    core(1, 0, 32'h100, 3'd2, 32'd0); slave(1, 0, 32'd0); cyc();
    core(0, 0, 32'h0, 3'd0, 32'd0); slave(1, 0, 32'hDEADBEEF);
    #1; chk("ld_rdata", dmem_rdata, 32'hDEADBEEF); chk("ld_ready", 32'(dmem_ready), 32'd1);
    cyc();

    // Store with two wait states.
    core(0, 1, 32'h200, 3'd2, 32'd0); slave(1, 0, 32'd0); cyc();
    core(0, 0, 32'h0, 3'd0, 32'h12345678); slave(0, 0, 32'd0); cyc();
    cyc();
    slave(1, 0, 32'd0);
    #1; chk("st_hwdata", hwdata, 32'h12345678);
    cyc();
    core(0, 0, 32'h0, 3'd0, 32'd0);
    #1; chk("st_stall", 32'(stall_cycles), 32'd2);
    cyc();

    // Back-to-back loads.
    core(1, 0, 32'h0, 3'd2, 32'd0); slave(1, 0, 32'd0); cyc();
    core(1, 0, 32'h4, 3'd2, 32'd0); slave(1, 0, 32'hA5A5_0000);
    #1; chk("b2b_htrans", 32'(htrans), 32'd2); chk("b2b_ready1", 32'(dmem_ready), 32'd1);
    cyc();
    core(0, 0, 32'h0, 3'd0, 32'd0); slave(1, 0, 32'h0000_5A5A);
    #1; chk("b2b_ready2", 32'(dmem_ready), 32'd1);
    cyc();

    // Slave error on a read.
    core(1, 0, 32'h300, 3'd2, 32'd0); slave(1, 0, 32'd0); cyc();
    core(0, 0, 32'h0, 3'd0, 32'd0); slave(0, 1, 32'd0);
    #1; chk("err1_ready", 32'(dmem_ready), 32'd0); chk("err1_htrans", 32'(htrans), 32'd0);
    cyc();
    slave(1, 1, 32'd0);
    #1; chk("err2_ready", 32'(dmem_ready), 32'd1); chk("err2_resp", 32'(dmem_resp), 32'd1);
    cyc();
    slave(1, 0, 32'd0); cyc();

    // Misaligned word read, then a read+write request that must go out as a write.
    core(1, 0, 32'h102, 3'd2, 32'd0);
    #1; chk("mis_htrans", 32'(htrans), ALIGN ? 32'd0 : 32'd2);
    cyc();
    core(1, 1, 32'h400, 3'd0, 32'd0);
    #1; chk("mis_resp", 32'(dmem_resp), ALIGN ? 32'd1 : 32'd0); chk("rw_hwrite", 32'(hwrite), 32'd1);
    cyc();
    core(0, 0, 32'h0, 3'd0, 32'h77); cyc();

    // Saturation of the stall counter, then clear while still stalled.
    core(1, 0, 32'h80, 3'd2, 32'd0); slave(1, 0, 32'd0); cyc();
    core(0, 0, 32'h0, 3'd0, 32'd0); slave(0, 0, 32'd0);
    for (int i = 0; i < 20; i++) cyc();
    #1; chk("sat_stall", 32'(stall_cycles), 32'(STALL_MAX));
    stall_clr = 1'b1; cyc();
    stall_clr = 1'b0;
    #1; chk("clr_stall", 32'(stall_cycles), 32'd0);
    slave(1, 0, 32'd0); cyc();

    // Reset during a waited data phase, with a new request pending.
    core(1, 0, 32'h40, 3'd2, 32'd0); slave(1, 0, 32'd0); cyc();
    core(1, 0, 32'h44, 3'd2, 32'd0); slave(0, 0, 32'd0); cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("arst_htrans", 32'(htrans), 32'd0);
    chk("arst_ready", 32'(dmem_ready), 32'd1);
    chk("arst_stall", 32'(stall_cycles), 32'd0);
    do_reset();

    // Randomized traffic with a protocol-following core and slave.
    for (int i = 0; i < 600; i++) begin
      if (m_last_ready) begin
        if ($urandom_range(0, 9) < 6) begin
          dmem_read  = 1'($urandom_range(0, 1));
          dmem_write = dmem_read ? ($urandom_range(0, 3) == 0) : 1'b1;
        end else begin
          dmem_read  = 1'b0;
          dmem_write = 1'b0;
        end
        dmem_size  = 3'($urandom_range(0, 2));
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
      end
      if (m_err) begin
        hready = ($urandom_range(0, 3) != 0);
        hresp  = 1'b1;
      end else if (m_dp) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin hready = 1'b1; hresp = 1'b0; end
          5, 6, 7:       begin hready = 1'b0; hresp = 1'b0; end
          default:       begin hready = 1'b0; hresp = 1'b1; end
        endcase
      end else begin
        hready = 1'b1;
        hresp  = 1'b0;
      end
      hrdata    = $urandom;
      stall_clr = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
